// File: rtl/mem_stage_lsu.sv
// MEM stage of the 5-stage MIPS core: handshaked byte/half/word load-store unit plus MEM/WB
// register. Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of masking.
module mem_stage_lsu (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Valid,
   input  logic [31:0] ALU_In,
   input  logic [31:0] StoreData,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [1:0]  MemSize,
   input  logic        MemSigned,
   input  logic [1:0]  MemToReg_In,
   input  logic        RegWrite_In,
   input  logic [4:0]  WriteReg_In,
   input  logic [31:0] PCI_In,
   output logic        Stall,
   output logic        MemReq,
   output logic        MemWe,
   output logic [31:0] MemAddr,
   output logic [31:0] MemWData,
   output logic [3:0]  MemBE,
   input  logic        MemReady,
   input  logic [31:0] MemRData,
   output logic        WB_Valid,
   output logic        WB_RegWrite,
   output logic [31:0] WB_ALU_Out,
   output logic [31:0] WB_DM_Out,
   output logic [31:0] WB_PCI_Out,
   output logic [1:0]  WB_MemToReg,
   output logic [4:0]  WB_WriteReg,
   output logic        Misaligned
);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e      state_q;
   logic        req_we_q, req_signed_q;
   logic [31:0] req_addr_q, req_wdata_q;
   logic [3:0]  req_be_q;
   logic [1:0]  req_size_q, req_off_q;
   logic [31:0] hold_alu_q, hold_pci_q;
   logic [1:0]  hold_mtr_q;
   logic        hold_rw_q;
   logic [4:0]  hold_wr_q;

   logic        mem_op, is_byte, is_half, misalign, start_req;
   logic [3:0]  be_calc;
   logic [31:0] wdata_calc, shifted, load_data;
   logic [1:0]  off_calc;

   assign mem_op  = Valid & (MemRead | MemWrite);
   assign is_byte = (MemSize == 2'b10);
   assign is_half = (MemSize == 2'b01);

`ifdef MEM_MISALIGN_TRAP_EN
   assign misalign = (is_half & ALU_In[0]) | (!is_byte & !is_half & (ALU_In[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   assign start_req = mem_op & !misalign;

   // Lane offset is pre-masked to the access size so extraction is a single shift.
   always_comb begin
      be_calc    = 4'b1111;
      wdata_calc = StoreData;
      off_calc   = 2'b00;
      if (is_byte) begin
         be_calc    = 4'b0001 << ALU_In[1:0];
         wdata_calc = {4{StoreData[7:0]}};
         off_calc   = ALU_In[1:0];
      end else if (is_half) begin
         be_calc    = ALU_In[1] ? 4'b1100 : 4'b0011;
         wdata_calc = {2{StoreData[15:0]}};
         off_calc   = {ALU_In[1], 1'b0};
      end
   end

   assign shifted = MemRData >> {req_off_q, 3'b000};

   always_comb begin
      load_data = shifted;
      if (req_size_q == 2'b10) begin
         load_data = {{24{req_signed_q & shifted[7]}}, shifted[7:0]};
      end else if (req_size_q == 2'b01) begin
         load_data = {{16{req_signed_q & shifted[15]}}, shifted[15:0]};
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q      <= StIdle;
         req_we_q     <= 1'b0;
         req_signed_q <= 1'b0;
         req_addr_q   <= '0;
         req_wdata_q  <= '0;
         req_be_q     <= '0;
         req_size_q   <= '0;
         req_off_q    <= '0;
         hold_alu_q   <= '0;
         hold_pci_q   <= '0;
         hold_mtr_q   <= '0;
         hold_rw_q    <= 1'b0;
         hold_wr_q    <= '0;
         WB_Valid     <= 1'b0;
         WB_RegWrite  <= 1'b0;
         WB_ALU_Out   <= '0;
         WB_DM_Out    <= '0;
         WB_PCI_Out   <= '0;
         WB_MemToReg  <= '0;
         WB_WriteReg  <= '0;
         Misaligned   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_req) begin
                  state_q      <= StBusy;
                  req_we_q     <= MemWrite & !MemRead;
                  req_signed_q <= MemSigned;
                  req_addr_q   <= {ALU_In[31:2], 2'b00};
                  req_wdata_q  <= wdata_calc;
                  req_be_q     <= be_calc;
                  req_size_q   <= MemSize;
                  req_off_q    <= off_calc;
                  hold_alu_q   <= ALU_In;
                  hold_pci_q   <= PCI_In;
                  hold_mtr_q   <= MemToReg_In;
                  hold_rw_q    <= RegWrite_In;
                  hold_wr_q    <= WriteReg_In;
                  WB_Valid     <= 1'b0;
                  WB_RegWrite  <= 1'b0;
                  Misaligned   <= 1'b0;
               end else begin
                  // Plain ALU ops, bubbles and trapped misaligned accesses retire directly.
                  WB_Valid    <= Valid;
                  WB_RegWrite <= Valid & RegWrite_In & !mem_op;
                  WB_ALU_Out  <= ALU_In;
                  WB_DM_Out   <= '0;
                  WB_PCI_Out  <= PCI_In;
                  WB_MemToReg <= MemToReg_In;
                  WB_WriteReg <= WriteReg_In;
                  Misaligned  <= mem_op & misalign;
               end
            end
            StBusy: begin
               Misaligned <= 1'b0;
               if (MemReady) begin
                  state_q     <= StIdle;
                  WB_Valid    <= 1'b1;
                  WB_RegWrite <= hold_rw_q;
                  WB_ALU_Out  <= hold_alu_q;
                  WB_DM_Out   <= req_we_q ? 32'd0 : load_data;
                  WB_PCI_Out  <= hold_pci_q;
                  WB_MemToReg <= hold_mtr_q;
                  WB_WriteReg <= hold_wr_q;
               end else begin
                  WB_Valid    <= 1'b0;
                  WB_RegWrite <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign MemReq   = (state_q == StBusy);
   assign MemWe    = req_we_q;
   assign MemAddr  = req_addr_q;
   assign MemWData = req_wdata_q;
   assign MemBE    = req_be_q;
   assign Stall    = !Rst & (((state_q == StIdle) & start_req) |
                             ((state_q == StBusy) & !MemReady));

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed cases from the test plan plus randomized
// instructions checked against a transaction-level model of lane selection and extension.
module tb_mem_stage_lsu;

`ifdef MEM_MISALIGN_TRAP_EN
   localparam bit Trap = 1'b1;
`else
   localparam bit Trap = 1'b0;
`endif

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        Valid = 1'b0;
   logic [31:0] ALU_In = '0, StoreData = '0, PCI_In = '0, MemRData = '0;
   logic        MemRead = 1'b0, MemWrite = 1'b0, MemSigned = 1'b0, RegWrite_In = 1'b0;
   logic [1:0]  MemSize = '0, MemToReg_In = '0;
   logic [4:0]  WriteReg_In = '0;
   logic        MemReady = 1'b0;
   logic        Stall, MemReq, MemWe, WB_Valid, WB_RegWrite, Misaligned;
   logic [31:0] MemAddr, MemWData, WB_ALU_Out, WB_DM_Out, WB_PCI_Out;
   logic [3:0]  MemBE;
   logic [1:0]  WB_MemToReg;
   logic [4:0]  WB_WriteReg;

   int n_checks = 0;
   int n_pass   = 0;

   mem_stage_lsu dut (
      .Clk(Clk), .Rst(Rst), .Valid(Valid), .ALU_In(ALU_In), .StoreData(StoreData),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize), .MemSigned(MemSigned),
      .MemToReg_In(MemToReg_In), .RegWrite_In(RegWrite_In), .WriteReg_In(WriteReg_In),
      .PCI_In(PCI_In), .Stall(Stall), .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
      .MemWData(MemWData), .MemBE(MemBE), .MemReady(MemReady), .MemRData(MemRData),
      .WB_Valid(WB_Valid), .WB_RegWrite(WB_RegWrite), .WB_ALU_Out(WB_ALU_Out),
      .WB_DM_Out(WB_DM_Out), .WB_PCI_Out(WB_PCI_Out), .WB_MemToReg(WB_MemToReg),
      .WB_WriteReg(WB_WriteReg), .Misaligned(Misaligned)
   );

   always #5 Clk = ~Clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
   endtask

   // Access width in bytes and first lane, straight from the size/address rules.
   function automatic int acc_bytes(input logic [1:0] sz);
      return (sz == 2'b10) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic int first_lane(input logic [1:0] sz, input logic [31:0] a);
      int w = acc_bytes(sz);
      return (w == 4) ? 0 : ((a % 4) / w) * w;
   endfunction

   function automatic logic [31:0] ld_value(input logic [1:0] sz, input logic sg,
                                            input logic [31:0] a, input logic [31:0] rd);
      longint unsigned v, mask;
      int w = acc_bytes(sz);
      v    = longint'(rd) >> (8 * first_lane(sz, a));
      mask = (64'd1 << (8 * w)) - 1;
      v    = v & mask;
      if (sg && w < 4 && ((v >> (8 * w - 1)) & 1) == 1) v = v | ~mask;
      return v[31:0];
   endfunction

   task automatic run_instr(input logic v, input logic mr, input logic mw, input logic [1:0] sz,
                            input logic sg, input logic [31:0] alu, input logic [31:0] sd,
                            input logic [31:0] pci, input logic [1:0] mtr, input logic rw,
                            input logic [4:0] wr, input logic [31:0] rdata, input int delay);
      logic        mem, store, fault, rdy;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd;
      int          w, s, stalls;
      mem   = v && (mr || mw);
      store = mw && !mr;
      w     = acc_bytes(sz);
      s     = first_lane(sz, alu);
      fault = Trap && mem && ((w == 2 && alu % 2 != 0) || (w == 4 && alu % 4 != 0));
      for (int n = 0; n < 4; n++) begin
         exp_be[n]            = (n >= s) && (n < s + w);
         exp_wd[8*n +: 8]     = sd[8*(n % w) +: 8];
      end
      @(negedge Clk);
      Valid = v; MemRead = mr; MemWrite = mw; MemSize = sz; MemSigned = sg; ALU_In = alu;
      StoreData = sd; PCI_In = pci; MemToReg_In = mtr; RegWrite_In = rw; WriteReg_In = wr;
      MemReady = 1'($urandom); MemRData = $urandom;
      #1;
      check_eq("idle_stall", 32'(Stall), 32'(mem && !fault));
      check_eq("idle_req", 32'(MemReq), 32'd0);
      @(posedge Clk); #1;
      if (!mem || fault) begin
         check_eq("wb_valid", 32'(WB_Valid), 32'(v));
         check_eq("wb_rw", 32'(WB_RegWrite), 32'(v && rw && !fault));
         check_eq("wb_alu", WB_ALU_Out, alu);
         check_eq("wb_pci", WB_PCI_Out, pci);
         check_eq("wb_mtr", 32'(WB_MemToReg), 32'(mtr));
         check_eq("wb_wr", 32'(WB_WriteReg), 32'(wr));
         check_eq("wb_dm", WB_DM_Out, 32'd0);
         check_eq("misaligned", 32'(Misaligned), 32'(fault));
         check_eq("no_req", 32'(MemReq), 32'd0);
      end else begin
         check_eq("bubble_valid", 32'(WB_Valid), 32'd0);
         stalls = 1;
         for (int k = 0; k <= delay; k++) begin
            @(negedge Clk);
            rdy      = (k == delay);
            MemReady = rdy;
            MemRData = rdy ? rdata : $urandom;
            #1;
            check_eq("req", 32'(MemReq), 32'd1);
            check_eq("we", 32'(MemWe), 32'(store));
            check_eq("addr", MemAddr, {alu[31:2], 2'b00});
            check_eq("be", 32'(MemBE), 32'(exp_be));
            if (store) check_eq("wdata", MemWData, exp_wd);
            if (Stall) stalls++;
            @(posedge Clk); #1;
            if (!rdy) check_eq("busy_bubble", 32'(WB_Valid | WB_RegWrite), 32'd0);
         end
         check_eq("stall_cycles", 32'(stalls), 32'(1 + delay));
         check_eq("done_valid", 32'(WB_Valid), 32'd1);
         check_eq("done_rw", 32'(WB_RegWrite), 32'(rw));
         check_eq("done_alu", WB_ALU_Out, alu);
         check_eq("done_pci", WB_PCI_Out, pci);
         check_eq("done_mtr", 32'(WB_MemToReg), 32'(mtr));
         check_eq("done_wr", 32'(WB_WriteReg), 32'(wr));
         check_eq("done_dm", WB_DM_Out, store ? 32'd0 : ld_value(sz, sg, alu, rdata));
         check_eq("done_mis", 32'(Misaligned), 32'd0);
      end
   endtask

   initial begin
      // Reset with random inputs on the pins.
      Rst = 1'b1;
      repeat (2) begin
         @(negedge Clk);
         Valid = 1'($urandom); MemRead = 1'($urandom); MemWrite = 1'($urandom);
         ALU_In = $urandom; StoreData = $urandom; MemSize = 2'($urandom);
         RegWrite_In = 1'($urandom); MemReady = 1'($urandom); MemRData = $urandom;
      end
      @(posedge Clk); #1;
      check_eq("rst_wb_valid", 32'(WB_Valid), 32'd0);
      check_eq("rst_wb_rw", 32'(WB_RegWrite), 32'd0);
      check_eq("rst_wb_alu", WB_ALU_Out | WB_DM_Out | WB_PCI_Out, 32'd0);
      check_eq("rst_wb_misc", 32'({WB_MemToReg, WB_WriteReg, Misaligned}), 32'd0);
      check_eq("rst_req", 32'({MemReq, MemWe, MemBE}), 32'd0);
      check_eq("rst_bus", MemAddr | MemWData, 32'd0);
      check_eq("rst_stall", 32'(Stall), 32'd0);
      @(negedge Clk);
      Rst = 1'b0; Valid = 1'b0;

      // ALU passthrough.
      run_instr(1, 0, 0, 2'b00, 0, 32'h1234, 32'h0, 32'h40, 2'b00, 1, 5'd5, 32'h0, 0);
      // Signed byte load at 0x103, ready on the third BUSY cycle.
      run_instr(1, 1, 0, 2'b10, 1, 32'h103, 32'h0, 32'h44, 2'b01, 1, 5'd7, 32'h80FF_FF11, 2);
      // Halfword store at 0x202.
      run_instr(1, 0, 1, 2'b01, 0, 32'h202, 32'hDEAD_BEEF, 32'h48, 2'b00, 0, 5'd0, 32'h0, 1);
      // Misaligned word load at 0x101.
      run_instr(1, 1, 0, 2'b00, 0, 32'h101, 32'h0, 32'h4C, 2'b01, 1, 5'd9, 32'hCAFE_F00D, 0);

      // Reset while BUSY with MemReady low.
      @(negedge Clk);
      Valid = 1; MemRead = 1; MemWrite = 0; MemSize = 2'b00; ALU_In = 32'h300;
      RegWrite_In = 1;
      @(posedge Clk);
      @(negedge Clk);
      MemReady = 0; #1;
      check_eq("pre_rst_req", 32'(MemReq), 32'd1);
      Rst = 1'b1;
      @(posedge Clk); #1;
      check_eq("abort_req", 32'(MemReq), 32'd0);
      check_eq("abort_valid", 32'(WB_Valid), 32'd0);
      @(negedge Clk);
      Rst = 1'b0; Valid = 1'b0;
      @(posedge Clk); #1;
      check_eq("abort_no_wb", 32'(WB_Valid | WB_RegWrite), 32'd0);

      // Randomized instruction stream, back-to-back.
      for (int i = 0; i < 80; i++) begin
         run_instr(1'($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom),
                   2'($urandom), 1'($urandom), $urandom, $urandom, $urandom, 2'($urandom),
                   1'($urandom), 5'($urandom), $urandom, int'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
